// File: rtl/ffn_pkg.sv
// Shared definitions for the FFN weight loader: default dimensions, segment
// sizes of the weight stream and the loader state encoding.
package ffn_pkg;

    localparam int FFN_EMBED_DIM  = 4;
    localparam int FFN_FFN_DIM    = 8;
    localparam int FFN_DATA_WIDTH = 16;

    // Words per stream segment, in stream order w1, b1, w2, b2
    localparam int W1_WORDS    = FFN_EMBED_DIM * FFN_FFN_DIM;
    localparam int B1_WORDS    = FFN_FFN_DIM;
    localparam int W2_WORDS    = FFN_FFN_DIM * FFN_EMBED_DIM;
    localparam int B2_WORDS    = FFN_EMBED_DIM;
    localparam int TOTAL_WORDS = W1_WORDS + B1_WORDS + W2_WORDS + B2_WORDS;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_W1 = 3'd1,
        ST_LOAD_B1 = 3'd2,
        ST_LOAD_W2 = 3'd3,
        ST_LOAD_B2 = 3'd4,
        ST_CHECK   = 3'd5,
        ST_COMMIT  = 3'd6
    } state_t;

    // Number of words expected in the segment owned by a LOAD_* state
    function automatic int seg_words(input state_t s, input int e, input int f);
        case (s)
            ST_LOAD_W1: return e * f;
            ST_LOAD_B1: return f;
            ST_LOAD_W2: return f * e;
            ST_LOAD_B2: return e;
            default:    return 1;
        endcase
    endfunction

endpackage

// File: rtl/ffn_weight_loader_if.sv
// Stream, control and committed-weight signals between a parameter source
// (master) and the weight loader (slave).
interface ffn_weight_loader_if #(
    parameter int EMBED_DIM  = 4,
    parameter int FFN_DIM    = 8,
    parameter int DATA_WIDTH = 16
);

    logic                                  load_start;
    logic                                  s_valid;
    logic [DATA_WIDTH-1:0]                 s_data;
    logic                                  s_ready;
    logic [EMBED_DIM*FFN_DIM*DATA_WIDTH-1:0] w1_flat;
    logic [FFN_DIM*DATA_WIDTH-1:0]         b1_flat;
    logic [FFN_DIM*EMBED_DIM*DATA_WIDTH-1:0] w2_flat;
    logic [EMBED_DIM*DATA_WIDTH-1:0]       b2_flat;
    logic                                  weights_ready;
    logic                                  load_done;
    logic                                  busy;
    logic                                  load_error;

    modport master (
        output load_start, s_valid, s_data,
        input  s_ready, w1_flat, b1_flat, w2_flat, b2_flat,
        input  weights_ready, load_done, busy, load_error
    );

    modport slave (
        input  load_start, s_valid, s_data,
        output s_ready, w1_flat, b1_flat, w2_flat, b2_flat,
        output weights_ready, load_done, busy, load_error
    );

endinterface

// File: rtl/ffn_wload_csum.sv
// Clearable running sum (mod 2^DATA_WIDTH) of accepted payload words.
module ffn_wload_csum #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  i_add,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_sum
);

    logic [DATA_WIDTH-1:0] r_sum;

    // Clear wins over add so a restart never carries a stale word into the new sum
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_sum <= '0;
        end else if (i_add) begin
            r_sum <= r_sum + i_data;
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/ffn_weight_loader.sv
// Streaming FFN weight loader: assembles w1, b1, w2, b2 into a shadow buffer
// and commits the complete set atomically to the flat output buses.
// Optional checksum word after b2 is enabled by defining FFN_WLOAD_CHECKSUM_EN.
module ffn_weight_loader
    import ffn_pkg::*;
#(
    parameter int EMBED_DIM  = FFN_EMBED_DIM,
    parameter int FFN_DIM    = FFN_FFN_DIM,
    parameter int DATA_WIDTH = FFN_DATA_WIDTH
) (
    input  logic clk,
    input  logic rst,
    ffn_weight_loader_if.slave bus
);

    localparam int N_W1  = EMBED_DIM * FFN_DIM;
    localparam int N_B1  = FFN_DIM;
    localparam int N_W2  = FFN_DIM * EMBED_DIM;
    localparam int N_B2  = EMBED_DIM;
    localparam int CNT_W = $clog2(N_W1 + 1);

    state_t                     r_state;
    logic [CNT_W-1:0]           r_cnt;
    logic                       r_s_ready;
    logic                       r_weights_ready;
    logic                       r_load_done;
    logic                       r_busy;
    logic [N_W1*DATA_WIDTH-1:0] r_sh_w1, r_w1;
    logic [N_B1*DATA_WIDTH-1:0] r_sh_b1, r_b1;
    logic [N_W2*DATA_WIDTH-1:0] r_sh_w2, r_w2;
    logic [N_B2*DATA_WIDTH-1:0] r_sh_b2, r_b2;

    logic   w_accept;
    logic   w_seg_last;
    int     w_base;
    state_t w_next_seg;

    assign w_accept   = bus.s_valid && r_s_ready;
    assign w_seg_last = (int'(r_cnt) == seg_words(r_state, EMBED_DIM, FFN_DIM) - 1);
    assign w_base     = int'(r_cnt) * DATA_WIDTH;

`ifdef FFN_WLOAD_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] w_sum;
    logic                  w_sum_add;
    logic                  r_load_error;

    assign w_sum_add = w_accept && !bus.load_start &&
                       (r_state inside {ST_LOAD_W1, ST_LOAD_B1, ST_LOAD_W2, ST_LOAD_B2});

    ffn_wload_csum #(.DATA_WIDTH(DATA_WIDTH)) u_csum (
        .clk     (clk),
        .rst     (rst),
        .i_clear (bus.load_start),
        .i_add   (w_sum_add),
        .i_data  (bus.s_data),
        .o_sum   (w_sum)
    );

    assign bus.load_error = r_load_error;
`else
    assign bus.load_error = 1'b0;
`endif

    // Segment that follows the current LOAD_* state once its last word lands
    always_comb begin
        w_next_seg = ST_IDLE;
        case (r_state)
            ST_LOAD_W1: w_next_seg = ST_LOAD_B1;
            ST_LOAD_B1: w_next_seg = ST_LOAD_W2;
            ST_LOAD_W2: w_next_seg = ST_LOAD_B2;
`ifdef FFN_WLOAD_CHECKSUM_EN
            ST_LOAD_B2: w_next_seg = ST_CHECK;
`else
            ST_LOAD_B2: w_next_seg = ST_COMMIT;
`endif
            default:    w_next_seg = ST_IDLE;
        endcase
    end

    // Shadow buffer write: word k of a segment lands in slice k; a word arriving with a restart is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_w1 <= '0;
            r_sh_b1 <= '0;
            r_sh_w2 <= '0;
            r_sh_b2 <= '0;
        end else if (w_accept && !bus.load_start) begin
            case (r_state)
                ST_LOAD_W1: r_sh_w1[w_base +: DATA_WIDTH] <= bus.s_data;
                ST_LOAD_B1: r_sh_b1[w_base +: DATA_WIDTH] <= bus.s_data;
                ST_LOAD_W2: r_sh_w2[w_base +: DATA_WIDTH] <= bus.s_data;
                ST_LOAD_B2: r_sh_b2[w_base +: DATA_WIDTH] <= bus.s_data;
                default: ;
            endcase
        end
    end

    // Load sequencer: segment counting, restart, optional checksum compare and atomic commit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_s_ready       <= 1'b0;
            r_weights_ready <= 1'b0;
            r_load_done     <= 1'b0;
            r_busy          <= 1'b0;
            r_w1            <= '0;
            r_b1            <= '0;
            r_w2            <= '0;
            r_b2            <= '0;
`ifdef FFN_WLOAD_CHECKSUM_EN
            r_load_error    <= 1'b0;
`endif
        end else begin
            r_load_done <= 1'b0;
`ifdef FFN_WLOAD_CHECKSUM_EN
            r_load_error <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (bus.load_start) begin
                        r_state         <= ST_LOAD_W1;
                        r_cnt           <= '0;
                        r_s_ready       <= 1'b1;
                        r_busy          <= 1'b1;
                        r_weights_ready <= 1'b0;
                    end
                end
                ST_LOAD_W1, ST_LOAD_B1, ST_LOAD_W2, ST_LOAD_B2: begin
                    if (bus.load_start) begin
                        r_state <= ST_LOAD_W1;
                        r_cnt   <= '0;
                    end else if (w_accept) begin
                        if (w_seg_last) begin
                            r_state   <= w_next_seg;
                            r_cnt     <= '0;
                            r_s_ready <= (w_next_seg != ST_COMMIT);
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
`ifdef FFN_WLOAD_CHECKSUM_EN
                ST_CHECK: begin
                    if (bus.load_start) begin
                        r_state <= ST_LOAD_W1;
                        r_cnt   <= '0;
                    end else if (w_accept) begin
                        r_s_ready <= 1'b0;
                        if (bus.s_data == w_sum) begin
                            r_state <= ST_COMMIT;
                        end else begin
                            r_state      <= ST_IDLE;
                            r_busy       <= 1'b0;
                            r_load_error <= 1'b1;
                        end
                    end
                end
`endif
                ST_COMMIT: begin
                    r_w1            <= r_sh_w1;
                    r_b1            <= r_sh_b1;
                    r_w2            <= r_sh_w2;
                    r_b2            <= r_sh_b2;
                    r_weights_ready <= 1'b1;
                    r_load_done     <= 1'b1;
                    r_busy          <= 1'b0;
                    r_state         <= ST_IDLE;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_s_ready <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready       = r_s_ready;
    assign bus.weights_ready = r_weights_ready;
    assign bus.load_done     = r_load_done;
    assign bus.busy          = r_busy;
    assign bus.w1_flat       = r_w1;
    assign bus.b1_flat       = r_b1;
    assign bus.w2_flat       = r_w2;
    assign bus.b2_flat       = r_b2;

endmodule
